// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- round sequencer for the AES-128 encryption datapath.
//
// Sequences one block through the initial AddRoundKey, NR-1 full rounds
// (SubBytes/ShiftRows, MixColumns, AddRoundKey) and a final round with
// MixColumns bypassed. It holds only control state; the state register,
// SubBytes/ShiftRows, MixColumns and key storage live in the datapath.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   start_valid/start_ready accept a plaintext block (ready only in IDLE)
//   abort                   synchronous cancel, highest priority
//   key_req/key_idx/key_ack round-key handshake, key_idx tracks round
//   st_load/st_sel          state-register load strobe and source select
//                           (0 pt^key, 1 SubBytes/ShiftRows, 2 MixColumns,
//                           3 state^key)
//   mix_en/mix_bypass       MixColumns enable / final-round bypass flag
//   round, busy             current round number, not idle
//   done_valid/done_ready   ciphertext handshake
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int SB_LAT  = 1,
  parameter int MIX_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       key_req,
  output logic [3:0] key_idx,
  input  logic       key_ack,
  output logic       st_load,
  output logic [1:0] st_sel,
  output logic       mix_en,
  output logic       mix_bypass,
  output logic [3:0] round,
  output logic       busy,
  output logic       done_valid,
  input  logic       done_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_MIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // cnt only needs to reach the larger of the two latencies minus one
  localparam int LMAX = (SB_LAT > MIX_LAT) ? SB_LAT : MIX_LAT;
  localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam logic [CW-1:0] SB_LAST  = CW'(SB_LAT - 1);
  localparam logic [CW-1:0] MIX_LAST = CW'(MIX_LAT - 1);
  localparam logic [3:0]    LAST_RND = 4'(NR);

  logic [2:0]    state, state_nx;
  logic [3:0]    round_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last_rnd, sb_last, mix_last;

  assign last_rnd = (round == LAST_RND);
  assign sb_last  = (cnt == SB_LAST);
  assign mix_last = (cnt == MIX_LAST);

  always_comb begin
    state_nx = state;
    round_nx = round;
    cnt_nx   = cnt;
    if (abort) begin
      state_nx = S_IDLE;
      round_nx = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: if (start_valid) begin
          state_nx = S_KEY;
          round_nx = '0;
          cnt_nx   = '0;
        end
        S_KEY: if (key_ack) begin
          // the key add of the last round ends the block; otherwise the
          // round counter advances here and only here
          if (last_rnd) state_nx = S_DONE;
          else begin
            state_nx = S_SUB;
            round_nx = round + 4'd1;
            cnt_nx   = '0;
          end
        end
        S_SUB: if (sb_last) begin
          cnt_nx   = '0;
          state_nx = last_rnd ? S_KEY : S_MIX;
        end else cnt_nx = cnt + 1'b1;
        S_MIX: if (mix_last) begin
          cnt_nx   = '0;
          state_nx = S_KEY;
        end else cnt_nx = cnt + 1'b1;
        S_DONE: if (done_ready) begin
          state_nx = S_IDLE;
          round_nx = '0;
        end
        default: begin
          state_nx = S_IDLE;
          round_nx = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      round <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      round <= round_nx;
      cnt   <= cnt_nx;
    end
  end

  // Moore decode except st_load/st_sel (key_ack) and the abort gating
  always_comb begin
    start_ready = (state == S_IDLE);
    busy        = (state != S_IDLE);
    mix_bypass  = busy && last_rnd;
    key_idx     = round;
    key_req     = 1'b0;
    st_load     = 1'b0;
    st_sel      = 2'd0;
    mix_en      = 1'b0;
    done_valid  = 1'b0;
    case (state)
      S_KEY: begin
        key_req = 1'b1;
        if (key_ack) begin
          st_load = 1'b1;
          st_sel  = (round == 4'd0) ? 2'd0 : 2'd3;
        end
      end
      S_SUB: if (sb_last) begin
        st_load = 1'b1;
        st_sel  = 2'd1;
      end
      S_MIX: begin
        mix_en = 1'b1;
        if (mix_last) begin
          st_load = 1'b1;
          st_sel  = 2'd2;
        end
      end
      S_DONE: done_valid = 1'b1;
      default: ;
    endcase
    if (abort) begin
      st_load    = 1'b0;
      st_sel     = 2'd0;
      key_req    = 1'b0;
      done_valid = 1'b0;
    end
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption datapath. It drives the state-register load selects, key-schedule requests and the MixColumns enable/bypass so that one block runs through the initial AddRoundKey, nine full rounds and the final round without MixColumns. It sits above the shared state register, SubBytes/ShiftRows, MixColumns and round-key storage. It holds no data itself, only control.

## Interface
- NR, 10: number of rounds; 4-bit counter, legal range 1..15
- SB_LAT, 1: cycles the SubBytes/ShiftRows result needs before it is valid; ≥1
- MIX_LAT, 2: cycles the registered MixColumns output needs after its operand is stable; ≥1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  plaintext present on datapath input
- start_ready  out  1  controller idle and able to accept
- abort  in  1  synchronous cancel, highest priority
- key_req  out  1  round key requested
- key_idx  out  4  index of requested round key (= round)
- key_ack  in  1  round key valid on key bus this cycle
- st_load  out  1  state register load strobe
- st_sel  out  2  state source: 0 = pt^key, 1 = SubBytes/ShiftRows, 2 = MixColumns, 3 = state^key
- mix_en  out  1  MixColumns stage enable
- mix_bypass  out  1  final round: MixColumns skipped
- round  out  4  current round number
- busy  out  1  not in IDLE
- done_valid  out  1  ciphertext valid in state register
- done_ready  in  1  consumer accepts ciphertext

## Operation
- States: IDLE, KEY, SUB, MIX, DONE. State register, round counter and latency counter cnt are updated on the clock. Outputs are decoded from state, round and cnt. st_load also depends on key_ack.
- IDLE: start_ready=1. When start_valid is high, the next state is KEY and round=0.
- KEY: key_req=1, key_idx=round. While key_ack=0, stay in KEY.
  - On key_ack: st_load=1 in the same cycle. st_sel=0 if round==0, else 3.
  - Then, if round==NR, go to DONE. Otherwise round increments and the next state is SUB with cnt=0.
- SUB: cnt counts up to SB_LAT-1. On cnt==SB_LAT-1: st_load=1, st_sel=1, cnt clears.
  - Next state is KEY if round==NR, else MIX.
- MIX: mix_en=1. cnt counts up to MIX_LAT-1. On the last count: st_load=1, st_sel=2, next state KEY.
- DONE: done_valid=1 until done_ready is high, then go to IDLE. round holds at NR until leaving DONE.
- mix_bypass = (round==NR) in every non-IDLE state. MIX is never entered while mix_bypass=1.
- busy = (state!=IDLE). st_sel is 0 whenever st_load=0.
- abort=1 in any state:
  - Next state is IDLE; round and cnt clear.
  - st_load, key_req and done_valid are forced to 0 in that cycle, even if key_ack is high.
  - abort in IDLE has no effect, and start_valid is ignored in that cycle.
- start_valid outside IDLE is ignored. key_ack outside KEY is ignored.
- Round counter increments only in the KEY→SUB transition. It never wraps within a block.

## Timing
- Reset values: state IDLE, round 0, cnt 0, start_ready 1, every other output 0.
- When key_ack is held high, KEY lasts 1 cycle. Otherwise KEY lasts until key_ack (unbounded wait, no timeout).
- Latency from the accepting edge to done_valid high, with key_ack tied high: 1 + (NR-1)·(SB_LAT+MIX_LAT+1) + (SB_LAT+1) cycles. For the defaults this is 39 cycles.
- Exactly 2·NR+1 + (NR-1) st_load pulses per block. For the defaults that is 30: 11 key adds, 10 SubBytes, 9 MixColumns.
- done_valid with done_ready already high: DONE lasts 1 cycle and IDLE follows on the next edge. Back-to-back blocks are therefore separated by ≥1 IDLE cycle.
- rst_n asserted mid-block: all state clears immediately and asynchronously. Outputs take their reset values without waiting for a clock edge.

## Test plan
- Reset, then start_valid pulse with key_ack=1 and done_ready=1:
  - done_valid rises exactly 39 cycles after the accept edge.
  - st_sel sequence is 0, then (1,2,3)×9, then 1,3.
  - key_idx over the KEY cycles is 0..10.
- key_ack stalled 5 cycles in round 4's KEY state: controller stays in KEY with key_req=1, key_idx=4 and no st_load. Total latency becomes 44 cycles.
- done_ready held low 3 cycles at DONE: done_valid stays 1 and round stays 10. start_valid during this period is ignored (start_ready=0). IDLE follows the cycle done_ready rises.
- abort asserted in round 6 MIX, in the same cycle as a key_ack in KEY, and in IDLE:
  - In the first two cases the controller is in IDLE with round=0 on the next edge and no st_load pulse occurs.
  - In IDLE, abort has no effect.
- rst_n dropped asynchronously mid-SUB of round 3: outputs reach reset values without a clock edge. A fresh block after release completes in 39 cycles.
- Final round check across the full run: mix_en is never high while round==10. mix_bypass is high only in round 10's SUB, KEY and DONE.
